// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier controller.
// Provides the FSM state type, the per-phase cycle counts, the data-memory
// address width and the derived counter widths.
package mult_seq_pkg;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned LOAD_CYCLES  = 4;
    localparam int unsigned MUL_CYCLES   = 16;
    localparam int unsigned STORE_CYCLES = 4;

    // One phase counter serves both LOAD and STORE (both four cycles long).
    localparam int unsigned PHASE_W = $clog2(LOAD_CYCLES);
    localparam int unsigned STEP_W  = $clog2(MUL_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        STORE,
        DONE
    } state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Byte-wide data-memory bus between the multiplier controller and its memory.
//   mem_addr  : byte address           (master -> slave)
//   mem_wr_en : write strobe           (master -> slave)
//   mem_wdata : write byte             (master -> slave)
//   mem_rdata : combinational read data for mem_addr (slave -> master)
interface mult_seq_ctrl_if;
    import mult_seq_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/booth_core.sv
// Radix-2 Booth datapath: 16x16 signed multiply, one step per enabled cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero all datapath state
//   load       : capture multiplicand a_i and multiplier b_i, zero accumulator
//   step       : perform one Booth step
//   a_i, b_i   : signed 16-bit operands
//   step_cnt   : number of steps taken since load
//   product    : signed 32-bit product (valid after MUL_CYCLES steps)
module booth_core
    import mult_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    input  logic [15:0]       a_i,
    input  logic [15:0]       b_i,
    output logic [STEP_W-1:0] step_cnt,
    output logic [31:0]       product
);

    // The multiplicand is shifted left each step instead of shifting the
    // accumulator right, so the accumulator holds the running product directly.
    logic [32:0]       acc_q, acc_d;
    logic [32:0]       mcand_q, mcand_d;
    logic [15:0]       mplr_q, mplr_d;
    logic              prev_q, prev_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              unused_acc_msb;

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        prev_d  = prev_q;
        step_d  = step_q;
        if (clr) begin
            acc_d   = '0;
            mcand_d = '0;
            mplr_d  = '0;
            prev_d  = 1'b0;
            step_d  = '0;
        end else if (load) begin
            acc_d   = '0;
            mcand_d = {{17{a_i[15]}}, a_i};
            mplr_d  = b_i;
            prev_d  = 1'b0;
            step_d  = '0;
        end else if (step) begin
            case ({mplr_q[0], prev_q})
                2'b01:   acc_d = acc_q + mcand_q;
                2'b10:   acc_d = acc_q - mcand_q;
                default: acc_d = acc_q;
            endcase
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            prev_d  = mplr_q[0];
            step_d  = step_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            prev_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prev_q  <= prev_d;
            step_q  <= step_d;
        end
    end

    // The extra accumulator bit only guards intermediate sums; the final
    // product always fits in 32 bits.
    assign unused_acc_msb = acc_q[32];
    assign step_cnt       = step_q;
    assign product        = acc_q[31:0];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential signed 16x16 multiplier controller. On start it reads operand
// bytes A[15:8], A[7:0], B[15:8], B[7:0] from BASE_A..BASE_A+3, runs 16
// Booth steps, writes product bytes [31:24]..[7:0] to BASE_P..BASE_P+3,
// then raises halt until the next start.
//   CLK      : system clock (rising edge)
//   reset_n  : asynchronous active-low reset
//   start    : run request, honoured in IDLE and DONE only
//   mem      : data-memory bus (master side)
//   halt     : registered done flag
//   cycle_ct : busy-cycle count
// Optional feature: define MULT_SEQ_CYCLE_CNT_EN to enable the busy-cycle
// counter; otherwise cycle_ct is tied to zero.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_A = 8'd1,
    parameter logic [ADDR_W-1:0] BASE_P = 8'd5
)(
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   start,
    mult_seq_ctrl_if.master        mem,
    output logic                   halt,
    output logic [15:0]            cycle_ct
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               halt_q, halt_d;

    logic               core_clr, core_load, core_step;
    logic [15:0]        core_b;
    logic [STEP_W-1:0]  step_cnt;
    logic [31:0]        product;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        halt_d        = 1'b0;
        core_clr      = 1'b0;
        core_load     = 1'b0;
        core_step     = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wr_en = 1'b0;
        mem.mem_wdata = '0;
        // The last operand byte bypasses b_q so the core loads on the same edge.
        core_b        = {b_q[15:8], mem.mem_rdata};

        case (state_q)
            IDLE, DONE: begin
                halt_d = (state_q == DONE);
                if (start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    a_d      = '0;
                    b_d      = '0;
                    halt_d   = 1'b0;
                    core_clr = 1'b1;
                end
            end
            LOAD: begin
                mem.mem_addr = BASE_A + ADDR_W'(cnt_q);
                cnt_d        = cnt_q + 1'b1;
                case (cnt_q)
                    2'd0:    a_d[15:8] = mem.mem_rdata;
                    2'd1:    a_d[7:0]  = mem.mem_rdata;
                    2'd2:    b_d[15:8] = mem.mem_rdata;
                    default: b_d[7:0]  = mem.mem_rdata;
                endcase
                if (cnt_q == PHASE_W'(LOAD_CYCLES - 1)) begin
                    core_load = 1'b1;
                    cnt_d     = '0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                core_step = 1'b1;
                if (step_cnt == STEP_W'(MUL_CYCLES - 1)) begin
                    state_d = STORE;
                    cnt_d   = '0;
                end
            end
            STORE: begin
                mem.mem_wr_en = 1'b1;
                mem.mem_addr  = BASE_P + ADDR_W'(cnt_q);
                case (cnt_q)
                    2'd0:    mem.mem_wdata = product[31:24];
                    2'd1:    mem.mem_wdata = product[23:16];
                    2'd2:    mem.mem_wdata = product[15:8];
                    default: mem.mem_wdata = product[7:0];
                endcase
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PHASE_W'(STORE_CYCLES - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            halt_q  <= halt_d;
        end
    end

    booth_core u_core (
        .clk      (CLK),
        .rst_n    (reset_n),
        .clr      (core_clr),
        .load     (core_load),
        .step     (core_step),
        .a_i      (a_q),
        .b_i      (core_b),
        .step_cnt (step_cnt),
        .product  (product)
    );

    assign halt = halt_q;

`ifdef MULT_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start && (state_q == IDLE || state_q == DONE)) begin
            cyc_d = '0;
        end else if (state_q == LOAD || state_q == MUL || state_q == STORE) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_ct = cyc_q;
`else
    assign cycle_ct = '0;
`endif

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter BASE_A, default 8'd1: data-memory address of operand A MSB; A LSB, B MSB and B LSB follow at +1, +2 and +3.
REQ-002 SHALL have parameter BASE_P, default 8'd5: data-memory address of product byte [31:24]; bytes [23:16], [15:8] and [7:0] follow at +1, +2 and +3.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled on the rising edge.
REQ-006 SHALL have port mem_addr, output, 8 bits: data-memory byte address.
REQ-007 SHALL have port mem_wr_en, output, 1 bit: data-memory write strobe.
REQ-008 SHALL have port mem_wdata, output, 8 bits: data-memory write byte.
REQ-009 SHALL have port mem_rdata, input, 8 bits: combinational read data for mem_addr, valid in the same cycle.
REQ-010 SHALL have port halt, output, 1 bit: done flag.
REQ-011 SHALL have port cycle_ct, output, 16 bits: busy-cycle count.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, MUL, STORE and DONE.
REQ-013 SHALL move IDLE->LOAD on the edge where start=1 and clear the operand registers, accumulator and step counter on that edge.
REQ-014 SHALL spend exactly 4 cycles in LOAD: mem_addr=BASE_A+k for k=0..3, capturing mem_rdata into A[15:8], A[7:0], B[15:8] and B[7:0] in that order; mem_wr_en=0 throughout.
REQ-015 SHALL spend exactly 16 cycles in MUL, one radix-2 Booth step per cycle, treating A and B as signed 16-bit and forming a signed 32-bit product.
REQ-016 SHALL spend exactly 4 cycles in STORE with mem_wr_en=1, mem_addr=BASE_P+k and mem_wdata=P[31-8k -: 8] for k=0..3.
REQ-017 SHALL enter DONE after STORE and assert halt on the 25th rising edge after the edge that sampled start; halt SHALL be a registered output.
REQ-018 SHALL hold halt=1 in DONE until start=1 is sampled; DONE->LOAD then, with halt=0 from that edge.
REQ-019 SHALL ignore start while in LOAD, MUL or STORE.
REQ-020 SHALL drive mem_addr=0, mem_wr_en=0 and mem_wdata=0 in IDLE and DONE.
REQ-021 SHALL produce the exact product for all operand pairs, including -32768*-32768=0x40000000 and -32768*1=0xFFFF8000; the accumulator SHALL be 33 bits to avoid overflow.

Reset
REQ-022 SHALL, while reset_n=0, asynchronously force state=IDLE, halt=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, cycle_ct=0 and all datapath registers to 0.
REQ-023 SHALL abort any operation on reset mid-run with no further memory writes; bytes already stored SHALL remain as written.

Configuration
REQ-024 SHALL, with MULT_SEQ_CYCLE_CNT_EN defined, increment cycle_ct on each edge where state is LOAD, MUL or STORE, clear it on the edge that samples start from IDLE or DONE, and hold it in DONE (24 after a complete run).
REQ-025 SHALL, without MULT_SEQ_CYCLE_CNT_EN, tie cycle_ct to 16'd0 and implement no counter logic.

Structure
REQ-026 SHALL take the state enum type, the LOAD/MUL/STORE cycle-count constants (4, 16, 4) and the address width from the shared package mult_seq_pkg.
REQ-027 SHALL place the Booth datapath (accumulator, multiplier shift register, step counter, product output) in the sub-module booth_core, controlled by load and step enables from the FSM.

Verification
REQ-028 SHALL cover: MEM[1..4]=00,03,00,07, start pulse -> MEM[5..8]=00,00,00,15 and halt rises 25 cycles after start.
REQ-029 SHALL cover: A=0x8000, B=0x8000 -> product 0x40000000; A=0xFFFF, B=0x0001 -> product 0xFFFFFFFF.
REQ-030 SHALL cover: start held high for 10 cycles mid-MUL -> single run, result and timing unchanged.
REQ-031 SHALL cover: reset_n pulsed low during STORE at k=1 -> halt=0, state IDLE, only MEM[5] written, MEM[6..8] unchanged.
REQ-032 SHALL cover: start sampled in DONE with new operands 0x1234 and 0xFFFE -> halt drops the next cycle, then MEM[5..8]=FF,FF,DB,98 and cycle_ct=24 with MULT_SEQ_CYCLE_CNT_EN defined, 0 without.
REQ-033 SHALL cover: 1000 random signed operand pairs -> product matches the reference OpA*OpB every run.
